paddle_controller: RTL



---
 rtl/pong_pkg.sv | 21 ++
 rtl/button_debounce.sv | 43 ++++
 rtl/paddle_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared geometry defaults, derived paddle limits and the detent direction type.
package pong_pkg;

    localparam int SCREEN_H_DEFAULT = 480;
    localparam int PADDLE_H_DEFAULT = 64;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    function automatic int y_max(input int screen_h, input int paddle_h);
        return screen_h - paddle_h;
    endfunction

    function automatic int y_rst(input int screen_h, input int paddle_h);
        return y_max(screen_h, paddle_h) / 2;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw switch, accepts a level only after it holds DEBOUNCE_CYCLES,
// and pulses pressed_pulse for one cycle on each accepted release->press flip.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pressed_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            level_q       <= 1'b0;
            cnt_q         <= '0;
            pressed_pulse <= 1'b0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            pressed_pulse <= 1'b0;
            // Any return to the accepted level restarts the stability count.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                level_q       <= sync2_q;
                cnt_q         <= '0;
                pressed_pulse <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_controller.sv
// One player's paddle: clamped vertical position driven by encoder detents plus a
// debounced serve pulse. Define PADDLE_ACCEL_EN to enable same-direction speed streaks.
module paddle_controller
    import pong_pkg::*;
#(
    parameter int SCREEN_H        = SCREEN_H_DEFAULT,
    parameter int PADDLE_H        = PADDLE_H_DEFAULT,
    parameter int Y_W             = 10,
    parameter int STEP            = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACCEL_WINDOW    = 2500000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up,
    input  logic           down,
    input  logic           button,
    input  logic           freeze,
    output logic [Y_W-1:0] paddle_y,
    output logic           serve,
    output logic           at_top,
    output logic           at_bottom
);

    localparam int           Y_MAX_I = y_max(SCREEN_H, PADDLE_H);
    localparam int           Y_RST_I = y_rst(SCREEN_H, PADDLE_H);
    localparam logic [Y_W:0] Y_MAX_W = (Y_W + 1)'(Y_MAX_I);

    // up/down are single-cycle strobes with no back-pressure: every high cycle is one
    // detent and is always accepted, including back-to-back cycles.
    dir_t         dir;
    logic [Y_W:0] step;
    logic [Y_W:0] y_ext;
    logic [Y_W:0] y_sum;
    logic [Y_W:0] y_next;

    always_comb begin
        dir = DIR_NONE;
        if (!freeze && up && !down) begin
            dir = DIR_UP;
        end else if (!freeze && down && !up) begin
            dir = DIR_DOWN;
        end
    end

`ifdef PADDLE_ACCEL_EN
    localparam int GAP_W = $clog2(ACCEL_WINDOW + 1);

    logic [GAP_W-1:0] gap_q;
    logic [1:0]       streak_q;
    logic [1:0]       streak_d;
    dir_t             last_dir_q;

    // The streak qualified by this detent scales its own step, so a broken streak
    // moves at base speed immediately.
    always_comb begin
        streak_d = 2'd0;
        if (dir == last_dir_q && gap_q < GAP_W'(ACCEL_WINDOW)) begin
            streak_d = (streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1;
        end
        step = (Y_W + 1)'(STEP * (1 + int'(streak_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q      <= GAP_W'(ACCEL_WINDOW);
            streak_q   <= 2'd0;
            last_dir_q <= DIR_NONE;
        end else if (dir != DIR_NONE) begin
            gap_q      <= '0;
            streak_q   <= streak_d;
            last_dir_q <= dir;
        end else begin
            if (gap_q < GAP_W'(ACCEL_WINDOW)) begin
                gap_q <= gap_q + GAP_W'(1);
            end
            if (freeze) begin
                streak_q <= 2'd0;
            end
        end
    end
`else
    always_comb begin
        step = (Y_W + 1)'(STEP);
    end
`endif

    // Compare before subtracting so the unsigned position never wraps.
    always_comb begin
        y_ext  = {1'b0, paddle_y};
        y_sum  = y_ext + step;
        y_next = y_ext;
        case (dir)
            DIR_UP:   y_next = (y_ext < step) ? '0 : y_ext - step;
            DIR_DOWN: y_next = (y_sum > Y_MAX_W) ? Y_MAX_W : y_sum;
            default:  y_next = y_ext;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            paddle_y  <= Y_W'(Y_RST_I);
            at_top    <= 1'b0;
            at_bottom <= 1'b0;
        end else begin
            paddle_y  <= y_next[Y_W-1:0];
            at_top    <= (y_next == '0);
            at_bottom <= (y_next == Y_MAX_W);
        end
    end

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_serve_debounce (
        .clk          (clk),
        .rst          (rst),
        .raw          (button),
        .pressed_pulse(serve)
    );

endmodule
